// File: rtl/debounce_filter.sv
`default_nettype none
// ============================================================================
// Module   : debounce_filter
// Purpose  : Synchronises a raw bouncy input and accepts a level change only
//            after STABLE_CYCLES equal samples; emits rise/fall strobes.
//            Optional macro DEBOUNCE_GLITCH_CNT_EN adds a saturating 8-bit
//            count of aborted transitions on port glitch_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module debounce_filter #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       d_in,
    output logic       d_out,
    output logic       rise_pulse,
    output logic       fall_pulse
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    output logic [7:0] glitch_cnt
`endif
);

    localparam int             CNT_W      = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] ACCEPT_CNT = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE_LOW   = 2'd0,
        CHECK_HIGH = 2'd1,
        IDLE_HIGH  = 2'd2,
        CHECK_LOW  = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_s;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   d_out_q, d_out_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    // Plain shift chain: stage 1 is bit 0, the synchronised sample is the MSB.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_in};
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
            d_out_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            d_out_q <= d_out_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        d_out_d = d_out_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            IDLE_LOW: begin
                if (sync_s) begin
                    state_d = CHECK_HIGH;
                    cnt_d   = CNT_ONE;
                end
            end
            CHECK_HIGH: begin
                if (!sync_s) begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == ACCEPT_CNT) begin
                    state_d = IDLE_HIGH;
                    cnt_d   = '0;
                    d_out_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            IDLE_HIGH: begin
                if (!sync_s) begin
                    state_d = CHECK_LOW;
                    cnt_d   = CNT_ONE;
                end
            end
            CHECK_LOW: begin
                if (sync_s) begin
                    state_d = IDLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == ACCEPT_CNT) begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                    d_out_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE_LOW;
                cnt_d   = '0;
                d_out_d = 1'b0;
            end
        endcase
    end

    assign d_out      = d_out_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic       abort_w;
    logic [7:0] glitch_q;

    // An abort is a CHECK state seeing the sample revert to the old level.
    assign abort_w = ((state_q == CHECK_HIGH) && !sync_s) ||
                     ((state_q == CHECK_LOW)  &&  sync_s);

    always_ff @(posedge clk) begin
        if (reset) begin
            glitch_q <= 8'd0;
        end else if (abort_w && (glitch_q != 8'hFF)) begin
            glitch_q <= glitch_q + 8'd1;
        end
    end

    assign glitch_cnt = glitch_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_debounce_filter.sv
`default_nettype none
// Testbench for debounce_filter: default instance plus a STABLE_CYCLES=2
// instance; pulses are checked against a queue of expected events.
module tb_debounce_filter;

    localparam int LAT  = 17;   // SYNC_STAGES + STABLE_CYCLES - 1, defaults
    localparam int LAT2 = 3;    // same with STABLE_CYCLES = 2

    logic clk = 1'b0;
    logic reset;
    logic d_in, d_in2;
    logic d_out, rise_pulse, fall_pulse;
    logic d_out2, rise_pulse2, fall_pulse2;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] glitch_cnt, glitch_cnt2;
`endif

    typedef struct {
        bit rise;
        int cyc;
    } ev_t;

    ev_t q1[$];
    ev_t q2[$];
    int  cyc = 0;
    int  n_cmp = 0;
    int  n_fail = 0;
    int  exp_glitch = 0;
    int  exp_glitch2 = 0;

    debounce_filter u_dut (
        .clk        (clk),
        .reset      (reset),
        .d_in       (d_in),
        .d_out      (d_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
`ifdef DEBOUNCE_GLITCH_CNT_EN
        ,
        .glitch_cnt (glitch_cnt)
`endif
    );

    debounce_filter #(
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (2)
    ) u_dut2 (
        .clk        (clk),
        .reset      (reset),
        .d_in       (d_in2),
        .d_out      (d_out2),
        .rise_pulse (rise_pulse2),
        .fall_pulse (fall_pulse2)
`ifdef DEBOUNCE_GLITCH_CNT_EN
        ,
        .glitch_cnt (glitch_cnt2)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge right after d_in changes: capture edge is cyc+1.
    task automatic exp1(input bit r, input int lat);
        ev_t e;
        e.rise = r;
        e.cyc  = cyc + 1 + lat;
        q1.push_back(e);
    endtask

    task automatic exp2(input bit r, input int lat);
        ev_t e;
        e.rise = r;
        e.cyc  = cyc + 1 + lat;
        q2.push_back(e);
    endtask

    task automatic monitor();
        ev_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (rise_pulse || fall_pulse) begin
                    n_cmp++;
                    if (q1.size() == 0) begin
                        n_fail++;
                        $display("FAIL dut1_unexpected_pulse: rise=%0b fall=%0b at cycle %0d, required no pulse",
                                 rise_pulse, fall_pulse, cyc);
                    end else begin
                        e = q1.pop_front();
                        if (rise_pulse !== e.rise || fall_pulse !== !e.rise ||
                            d_out !== e.rise || cyc != e.cyc) begin
                            n_fail++;
                            $display("FAIL dut1_pulse: got rise=%0b fall=%0b d_out=%0b cycle=%0d, required rise=%0b fall=%0b d_out=%0b cycle=%0d",
                                     rise_pulse, fall_pulse, d_out, cyc, e.rise, !e.rise, e.rise, e.cyc);
                        end
                    end
                end
                if (rise_pulse2 || fall_pulse2) begin
                    n_cmp++;
                    if (q2.size() == 0) begin
                        n_fail++;
                        $display("FAIL dut2_unexpected_pulse: rise=%0b fall=%0b at cycle %0d, required no pulse",
                                 rise_pulse2, fall_pulse2, cyc);
                    end else begin
                        e = q2.pop_front();
                        if (rise_pulse2 !== e.rise || fall_pulse2 !== !e.rise ||
                            d_out2 !== e.rise || cyc != e.cyc) begin
                            n_fail++;
                            $display("FAIL dut2_pulse: got rise=%0b fall=%0b d_out=%0b cycle=%0d, required rise=%0b fall=%0b d_out=%0b cycle=%0d",
                                     rise_pulse2, fall_pulse2, d_out2, cyc, e.rise, !e.rise, e.rise, e.cyc);
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        d_in  = 1'b0;
        d_in2 = 1'b0;
        fork
            monitor();
        join_none

        tick(4);
        check("reset_d_out", 32'(d_out), 0);
        check("reset_rise", 32'(rise_pulse), 0);
        check("reset_fall", 32'(fall_pulse), 0);
        check("reset_d_out2", 32'(d_out2), 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check("reset_glitch", 32'(glitch_cnt), 0);
`endif
        reset = 1'b0;
        tick(3);

        // Clean rise then clean fall
        d_in = 1'b1; exp1(1'b1, LAT); tick(25);
        check("rise_level", 32'(d_out), 1);
        d_in = 1'b0; exp1(1'b0, LAT); tick(25);
        check("fall_level", 32'(d_out), 0);

        // Bounce: 5 high, 3 low, then held high
        d_in = 1'b1; tick(5);
        d_in = 1'b0; tick(3);
        check("bounce_no_change", 32'(d_out), 0);
        d_in = 1'b1; exp1(1'b1, LAT); exp_glitch++; tick(25);
        check("bounce_level", 32'(d_out), 1);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check("bounce_glitch", 32'(glitch_cnt), 32'(exp_glitch));
`endif
        d_in = 1'b0; exp1(1'b0, LAT); tick(25);

        // 15-cycle excursion is rejected
        d_in = 1'b1; tick(15);
        d_in = 1'b0; exp_glitch++; tick(25);
        check("short15_level", 32'(d_out), 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check("short15_glitch", 32'(glitch_cnt), 32'(exp_glitch));
`endif

        // Exactly 16 cycles is accepted; the immediate reversal starts a new check
        d_in = 1'b1; exp1(1'b1, LAT); tick(16);
        d_in = 1'b0; exp1(1'b0, LAT); tick(25);
        check("exact16_level", 32'(d_out), 0);

        // Reset while cnt == 10 in CHECK_HIGH, d_in held high throughout
        d_in = 1'b1; tick(12);
        reset = 1'b1; tick(3);
        check("midreset_d_out", 32'(d_out), 0);
        exp_glitch  = 0;
        exp_glitch2 = 0;
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check("midreset_glitch", 32'(glitch_cnt), 0);
`endif
        reset = 1'b0; exp1(1'b1, LAT); tick(25);
        check("midreset_level", 32'(d_out), 1);
        d_in = 1'b0; exp1(1'b0, LAT); tick(25);

        // STABLE_CYCLES=2: one-cycle glitch rejected, two-cycle high accepted
        d_in2 = 1'b1; tick(1);
        d_in2 = 1'b0; exp_glitch2++; tick(6);
        check("b2_glitch_level", 32'(d_out2), 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check("b2_glitch_cnt", 32'(glitch_cnt2), 32'(exp_glitch2));
`endif
        d_in2 = 1'b1; exp2(1'b1, LAT2); tick(2);
        d_in2 = 1'b0; exp2(1'b0, LAT2); tick(8);
        check("b2_final_level", 32'(d_out2), 0);

`ifdef DEBOUNCE_GLITCH_CNT_EN
        // 300 aborted checks saturate the counter
        for (int i = 0; i < 300; i++) begin
            d_in = 1'b1; tick(2);
            d_in = 1'b0; tick(2);
            if (exp_glitch < 255) exp_glitch++;
        end
        tick(5);
        check("sat_glitch", 32'(glitch_cnt), 32'(exp_glitch));
        check("sat_level", 32'(d_out), 0);
`endif

        check("dut1_pending_events", 32'(q1.size()), 0);
        check("dut2_pending_events", 32'(q2.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
